pc_sequencer: RTL
=================

# pc_sequencer

Program-counter sequencer for the 8-bit accumulator CPU; replaces the free-running PC. Owns the registered PC, the ALU flags register, conditional-jump evaluation, and a small hardware return-address stack for CALL/RET. Takes decoded strobes from the control unit and ALU flag bits, and drives the instruction-memory address. Provides run, stall, halt and fault sequencing.

## Interface
- PC_W, 8, PC and jump-target width.
- STACK_DEPTH, 4, return-stack entries (power of two, 2–16).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous and active-low.
- run  in  1  pulse; starts from IDLE or resumes from HALT.
- stall  in  1  freezes PC, flags, stack and state for this cycle.
- flags_write  in  1  latch alu_flags at end of cycle.
- alu_flags  in  4  {V,C,N,Z} from the ALU.
- is_jump  in  1  current instruction is a jump.
- jump_cond  in  4  condition code (see Operation).
- is_call  in  1  current instruction is CALL.
- is_ret  in  1  current instruction is RET.
- is_halt  in  1  current instruction is HALT.
- target  in  PC_W  literal jump/call target.
- pc  out  PC_W  registered instruction address.
- flags  out  4  registered {V,C,N,Z}.
- halted  out  1  high in HALT.
- fault  out  1  high in FAULT.
- sp  out  $clog2(STACK_DEPTH)+1  stack occupancy.

## Operation
- States: IDLE, RUN, HALT, FAULT.
- Reset values: pc=RESET_PC, flags=0, sp=0, state=IDLE, halted=0, fault=0.
- IDLE: the PC holds and all strobes are ignored. `run` moves the block to RUN, and execution starts at the current PC.
- RUN, per cycle with stall=0, next-PC priority:
  - is_halt: the PC holds and the block enters HALT.
  - is_ret: pop the stack into the PC.
  - is_call: push pc+1 and load target.
  - is_jump with the condition true: load target.
  - Otherwise: pc+1.
- Multiple strobes asserted together resolve by that priority; the losing strobes are ignored.
- jump_cond codes, evaluated on the registered flags:
  - 0 always, 1 Z, 2 !Z, 3 !Z&!N, 4 N, 5 !N, 6 Z|N, 7 C, 8 V.
  - 9–15 never; these fall through to pc+1.
- Flags use the registered value, so an instruction that writes flags and jumps in the same cycle sees the old flags. flags_write is honoured in RUN only, independent of next-PC selection.
- Arithmetic: pc+1 is modulo 2^PC_W (0xFF→0x00). The pushed value pc+1 wraps the same way.
- Stack errors:
  - Push with sp==STACK_DEPTH (overflow): enter FAULT.
  - Pop with sp==0 (underflow): enter FAULT.
  - In both cases the PC holds at the faulting instruction and the stack is unchanged.
- HALT: `run` resumes at pc+1 in RUN.
- FAULT: only rst_n exits; `run` is ignored.
- stall=1: no state, PC, flag or stack change, in any state.
- rst_n asserted in any state or mid-stall returns all outputs to reset values immediately (asynchronous).

## Timing
- pc, flags, sp, halted and fault are all registered; no combinational input→output path.
- Instruction memory is combinational, so one instruction executes per cycle; taken jumps cost no extra cycle.
- Edges:
  - `run` sampled at edge N makes state RUN after edge N.
  - The first PC advance happens at edge N+1.
  - A CALL at edge N shows target on pc and sp+1 after edge N.
  - flags_write at edge N is visible to the instruction at edge N+1.
- Reset release is synchronised internally with a 2-flop deassert, so the first `run` is honoured two edges after rst_n rises.

## Configuration
- PC_SEQ_STACK_EN defined: CALL/RET, the return stack and the overflow/underflow fault are implemented.
- PC_SEQ_STACK_EN undefined:
  - is_call and is_ret are ignored (treated as pc+1), and the stack is not synthesised.
  - sp is tied to 0, and FAULT is unreachable (fault tied 0).
  - Ports are unchanged.

## Structure
- Shared package cpu_pkg holds:
  - the state enum (IDLE/RUN/HALT/FAULT);
  - the jump_cond code constants (JC_ALWAYS..JC_V, JC_NEVER);
  - the flag bit indices (FLAG_Z=0, FLAG_N=1, FLAG_C=2, FLAG_V=3).
- One sub-module, return_stack: a parameterised LIFO with push/pop/full/empty/count, instantiated only under PC_SEQ_STACK_EN.
- Condition evaluation is a function in cpu_pkg, reused by the control unit's tests.

## Test plan
- Reset, then run: pc=0x00 until run, then 0x01, 0x02…; pc wraps 0xFF→0x00; halted=0, fault=0.
- Conditional jump:
  - flags_write with alu_flags=4'b0001 (Z), then is_jump, cond=1, target=0x40 → pc=0x40.
  - Same with cond=2 → pc+1.
  - Same-cycle flags_write+jump uses the old flags.
- Nested calls: CALL 0x10 at pc 0x05, CALL 0x20 at 0x11 → sp=2; RET → pc=0x12; RET → pc=0x06, sp=0.
- Stack faults:
  - Fifth CALL with STACK_DEPTH=4 → fault=1, pc holds, sp=4; run ignored.
  - RET with sp=0 → fault=1.
  - rst_n low clears both faults.
- Halt/stall:
  - is_halt at 0x07 → halted=1, pc=0x07 held; run → pc=0x08.
  - stall=1 during a CALL → pc, sp and flags unchanged.
- Priority and macro:
  - is_ret+is_jump together → pop wins.
  - Without PC_SEQ_STACK_EN, CALL at 0x03 → pc=0x04, sp=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: sequencer states, jump condition codes, flag bit positions
// and the branch-condition evaluator shared by the sequencer and the control unit.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } seq_state_t;

  localparam logic [3:0] JC_ALWAYS = 4'd0;
  localparam logic [3:0] JC_Z      = 4'd1;
  localparam logic [3:0] JC_NZ     = 4'd2;
  localparam logic [3:0] JC_GT     = 4'd3;
  localparam logic [3:0] JC_N      = 4'd4;
  localparam logic [3:0] JC_NN     = 4'd5;
  localparam logic [3:0] JC_LE     = 4'd6;
  localparam logic [3:0] JC_C      = 4'd7;
  localparam logic [3:0] JC_V      = 4'd8;
  localparam logic [3:0] JC_NEVER  = 4'd9;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  // Codes 9..15 are all "never" so unused encodings fall through to pc+1.
  function automatic logic cond_true(input logic [3:0] jc, input logic [3:0] f);
    logic z, n, c, v;
    z = f[FLAG_Z];
    n = f[FLAG_N];
    c = f[FLAG_C];
    v = f[FLAG_V];
    case (jc)
      JC_ALWAYS: cond_true = 1'b1;
      JC_Z:      cond_true = z;
      JC_NZ:     cond_true = !z;
      JC_GT:     cond_true = !z && !n;
      JC_N:      cond_true = n;
      JC_NN:     cond_true = !n;
      JC_LE:     cond_true = z || n;
      JC_C:      cond_true = c;
      JC_V:      cond_true = v;
      default:   cond_true = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/return_stack.sv
// Return-address LIFO with occupancy count; push/pop take effect at the clock edge.
// Latency: top_dat/count reflect a push or pop one cycle later.
// Backpressure: push when full / pop when empty are dropped; the caller faults instead.
module return_stack
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             push_dat,
  output logic [W-1:0]             top_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] top_idx;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  // When full the low index bits wrap to 0, so minus one lands on DEPTH-1.
  assign top_idx = count[AW-1:0] - AW'(1);
  assign top_dat = mem[top_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 count <= '0;
    else if (clr)               count <= '0;
    else if (push && !full)     count <= count + (AW+1)'(1);
    else if (pop && !empty)     count <= count - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (push && !full && !clr) mem[count[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: PC, flags, jump evaluation, CALL/RET stack (PC_SEQ_STACK_EN).
// Latency: one instruction per cycle, all outputs registered; taken jumps cost nothing.
// Backpressure: stall freezes every register for the cycle, in any state.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_W        = 8,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_PC    = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            run,
  input  logic                            stall,
  input  logic                            flags_write,
  input  logic [3:0]                      alu_flags,
  input  logic                            is_jump,
  input  logic [3:0]                      jump_cond,
  input  logic                            is_call,
  input  logic                            is_ret,
  input  logic                            is_halt,
  input  logic [PC_W-1:0]                 target,
  output logic [PC_W-1:0]                 pc,
  output logic [3:0]                      flags,
  output logic                            halted,
  output logic                            fault,
  output logic [$clog2(STACK_DEPTH):0]    sp
);

  seq_state_t      state_q;
  logic [1:0]      rst_sync_q;
  logic            rst_ok;
  logic [PC_W-1:0] pc_inc;

  // Reset asserts immediately but releases two edges later, clear of rst_n timing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_ok = rst_sync_q[1];
  assign pc_inc = pc + PC_W'(1);

`ifdef PC_SEQ_STACK_EN
  logic            in_run, ret_sel, call_sel, stk_full, stk_empty;
  logic [PC_W-1:0] stk_top;

  assign in_run   = rst_ok && !stall && (state_q == RUN);
  assign ret_sel  = in_run && !is_halt && is_ret;
  assign call_sel = in_run && !is_halt && !is_ret && is_call;

  return_stack #(.DEPTH(STACK_DEPTH), .W(PC_W)) u_stack (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (!rst_ok),
    .push     (call_sel),
    .pop      (ret_sel),
    .push_dat (pc_inc),
    .top_dat  (stk_top),
    .full     (stk_full),
    .empty    (stk_empty),
    .count    (sp)
  );
`else
  logic unused_call_ret;
  assign unused_call_ret = is_call ^ is_ret;
  assign sp              = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc      <= PC_W'(RESET_PC);
      flags   <= '0;
      halted  <= 1'b0;
      fault   <= 1'b0;
    end else if (!rst_ok) begin
      state_q <= IDLE;
      pc      <= PC_W'(RESET_PC);
      flags   <= '0;
      halted  <= 1'b0;
      fault   <= 1'b0;
    end else if (!stall) begin
      case (state_q)
        IDLE: if (run) state_q <= RUN;
        HALT: if (run) begin
          state_q <= RUN;
          halted  <= 1'b0;
          pc      <= pc_inc;
        end
        RUN: begin
          if (flags_write) flags <= alu_flags;
          if (is_halt) begin
            state_q <= HALT;
            halted  <= 1'b1;
          end
`ifdef PC_SEQ_STACK_EN
          else if (ret_sel) begin
            if (stk_empty) begin
              state_q <= FAULT;
              fault   <= 1'b1;
            end else begin
              pc <= stk_top;
            end
          end else if (call_sel) begin
            if (stk_full) begin
              state_q <= FAULT;
              fault   <= 1'b1;
            end else begin
              pc <= target;
            end
          end
`endif
          // Condition uses the registered flags, not this cycle's alu_flags.
          else if (is_jump && cond_true(jump_cond, flags)) pc <= target;
          else pc <= pc_inc;
        end
        default: ;
      endcase
    end
  end

endmodule
